// File: rtl/regfile_port_arbiter.sv
// Shares the single-port 32x32 register file between writeback and two operand
// readers: bounded write bursts, round-robin reads, writes to x0 suppressed.
module regfile_port_arbiter #(
  parameter int MAX_WR_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_rd,
  input  logic [31:0] wr_data,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [4:0]  rq0_rs1,
  input  logic [4:0]  rq0_rs2,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [4:0]  rq1_rs1,
  input  logic [4:0]  rq1_rs2,
  output logic        rf_enable,
  output logic        rf_read_write,
  output logic [4:0]  rf_rd,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [31:0] rf_din,
  input  logic [31:0] rf_a,
  input  logic [31:0] rf_b,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_a,
  output logic [31:0] rsp_b
);

  localparam int CW = $clog2(MAX_WR_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WR_BURST);

  logic [CW-1:0] wr_cnt;
  logic          rr;
  logic          read_pending;
  logic          wr_grant;
  logic          rd_grant;
  logic          rd_sel;

  // Writes win until the burst limit is reached while a read waits; no grants in reset.
  always_comb begin
    read_pending = rq0_valid | rq1_valid;
    wr_grant     = !reset && wr_valid && (!read_pending || (wr_cnt < CNT_MAX));
    rd_grant     = !reset && !wr_grant && read_pending;
    if (rq0_valid && rq1_valid) rd_sel = rr;
    else                        rd_sel = rq1_valid;
  end

  always_comb begin
    wr_ready      = wr_grant;
    rq0_ready     = rd_grant && !rd_sel;
    rq1_ready     = rd_grant && rd_sel;
    rf_enable     = 1'b0;
    rf_read_write = 1'b0;
    rf_rd         = '0;
    rf_rs1        = '0;
    rf_rs2        = '0;
    rf_din        = '0;
    if (wr_grant) begin
      // x0 is not hardwired in the register file, so the write is consumed but never enabled
      rf_enable     = (wr_rd != 5'd0);
      rf_read_write = 1'b1;
      rf_rd         = wr_rd;
      rf_din        = wr_data;
    end else if (rd_grant) begin
      rf_enable = 1'b1;
      rf_rs1    = rd_sel ? rq1_rs1 : rq0_rs1;
      rf_rs2    = rd_sel ? rq1_rs2 : rq0_rs2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt    <= '0;
      rr        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      rsp_valid <= rd_grant;
      if (rd_grant) begin
        rsp_id <= rd_sel;
        rr     <= !rd_sel;
      end
      if (rd_grant || !read_pending)
        wr_cnt <= '0;
      else if (wr_grant && (wr_cnt != CNT_MAX))
        wr_cnt <= wr_cnt + CW'(1);
    end
  end

  assign rsp_a = rf_a;
  assign rsp_b = rf_b;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a register-file stand-in, a rule-level arbiter
// model and a response scoreboard, driven by directed sequences then random traffic.
module tb_regfile_port_arbiter;

  localparam int MAX_WR_BURST = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        rq0_valid, rq0_ready, rq1_valid, rq1_ready;
  logic [4:0]  rq0_rs1, rq0_rs2, rq1_rs1, rq1_rs2;
  logic        rf_enable, rf_read_write;
  logic [4:0]  rf_rd, rf_rs1, rf_rs2;
  logic [31:0] rf_din;
  logic [31:0] rf_a = '0;
  logic [31:0] rf_b = '0;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_a, rsp_b;

  regfile_port_arbiter #(.MAX_WR_BURST(MAX_WR_BURST)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rd(wr_rd), .wr_data(wr_data),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_rs1(rq0_rs1), .rq0_rs2(rq0_rs2),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_rs1(rq1_rs1), .rq1_rs2(rq1_rs2),
    .rf_enable(rf_enable), .rf_read_write(rf_read_write), .rf_rd(rf_rd),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_din(rf_din), .rf_a(rf_a), .rf_b(rf_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_a(rsp_a), .rsp_b(rsp_b)
  );

  always #5 clock = ~clock;

  // Register-file stand-in: x0 is an ordinary storage cell, exactly like the real array.
  logic [31:0] rf_mem [32];
  always @(posedge clock) begin
    if (rf_enable) begin
      if (rf_read_write) rf_mem[rf_rd] <= rf_din;
      else begin
        rf_a <= rf_mem[rf_rs1];
        rf_b <= rf_mem[rf_rs2];
      end
    end
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_regs [32];
  int          wr_streak = 0;
  logic        pref = 1'b0;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic        wr_taken = 1'b0, rq0_taken = 1'b0, rq1_taken = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [4:0] wrd, input logic [31:0] wdat,
                               input logic v0, input logic [4:0] a0, input logic [4:0] b0,
                               input logic v1, input logic [4:0] a1, input logic [4:0] b1);
    wr_valid  = wv;  wr_rd   = wrd; wr_data = wdat;
    rq0_valid = v0;  rq0_rs1 = a0;  rq0_rs2 = b0;
    rq1_valid = v1;  rq1_rs1 = a1;  rq1_rs2 = b1;
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares grants against the arbitration rules and pops responses as they appear.
  always @(negedge clock) begin
    logic pending, exp_w, exp_r, exp_sel;
    rsp_t e;
    cycle++;
    if (reset) begin
      checkOutput("reset_wr_ready", {31'b0, wr_ready}, 32'd0);
      checkOutput("reset_rq0_ready", {31'b0, rq0_ready}, 32'd0);
      checkOutput("reset_rq1_ready", {31'b0, rq1_ready}, 32'd0);
      checkOutput("reset_rf_enable", {31'b0, rf_enable}, 32'd0);
      checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
      exp_q.delete();
      wr_streak = 0;
      pref      = 1'b0;
      wr_taken  = 1'b0; rq0_taken = 1'b0; rq1_taken = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) checkOutput("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          checkOutput("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
          checkOutput("rsp_a", rsp_a, e.a);
          checkOutput("rsp_b", rsp_b, e.b);
          checkOutput("rsp_latency", cycle, e.due);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
        checkOutput("rsp_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end

      pending = rq0_valid || rq1_valid;
      exp_w   = wr_valid && (!pending || wr_streak < MAX_WR_BURST);
      exp_r   = !exp_w && pending;
      exp_sel = (rq0_valid && rq1_valid) ? pref : rq1_valid;

      checkOutput("wr_ready", {31'b0, wr_ready}, {31'b0, exp_w});
      checkOutput("rq0_ready", {31'b0, rq0_ready}, {31'b0, exp_r && !exp_sel});
      checkOutput("rq1_ready", {31'b0, rq1_ready}, {31'b0, exp_r && exp_sel});
      if (exp_w) begin
        checkOutput("wr_rf_enable", {31'b0, rf_enable}, {31'b0, wr_rd != 5'd0});
        checkOutput("wr_rf_read_write", {31'b0, rf_read_write}, 32'd1);
        checkOutput("wr_rf_rd", {27'b0, rf_rd}, {27'b0, wr_rd});
        checkOutput("wr_rf_din", rf_din, wr_data);
        if (wr_rd != 5'd0) ref_regs[wr_rd] = wr_data;
      end else if (exp_r) begin
        checkOutput("rd_rf_enable", {31'b0, rf_enable}, 32'd1);
        checkOutput("rd_rf_read_write", {31'b0, rf_read_write}, 32'd0);
        checkOutput("rd_rf_rs1", {27'b0, rf_rs1}, {27'b0, exp_sel ? rq1_rs1 : rq0_rs1});
        checkOutput("rd_rf_rs2", {27'b0, rf_rs2}, {27'b0, exp_sel ? rq1_rs2 : rq0_rs2});
        e.id  = exp_sel;
        e.a   = ref_regs[exp_sel ? rq1_rs1 : rq0_rs1];
        e.b   = ref_regs[exp_sel ? rq1_rs2 : rq0_rs2];
        e.due = cycle + 1;
        exp_q.push_back(e);
      end else begin
        checkOutput("idle_rf_enable", {31'b0, rf_enable}, 32'd0);
        checkOutput("idle_rf_addr", {17'b0, rf_rd, rf_rs1, rf_rs2}, 32'd0);
        checkOutput("idle_rf_din", rf_din, 32'd0);
      end

      if (!pending)   wr_streak = 0;
      else if (exp_w) wr_streak = (wr_streak < MAX_WR_BURST) ? wr_streak + 1 : wr_streak;
      else if (exp_r) begin
        wr_streak = 0;
        pref      = !exp_sel;
      end
      wr_taken  = exp_w;
      rq0_taken = exp_r && !exp_sel;
      rq1_taken = exp_r && exp_sel;
    end
  end

  logic        r_wv, r_v0, r_v1;
  logic [4:0]  r_wrd, r_a0, r_b0, r_a1, r_b1;
  logic [31:0] r_wdat;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]   = '0;
      ref_regs[i] = '0;
    end
    reset = 1'b1;
    applyStimulus(1, 5'd3, 32'h1, 1, 5'd1, 5'd2, 1, 5'd3, 5'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Populate a few registers, then write x5 and read it back the next cycle.
    applyStimulus(1, 5'd1, 32'h1111_0001, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd2, 32'h2222_0002, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd3, 32'h3333_0003, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd5, 5'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // A write to x0 must be consumed without touching the array.
    applyStimulus(1, 5'd0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 1, 5'd3, 5'd5);
    for (int i = 0; i < 15; i++) applyStimulus(1, 5'd7, 32'hCAFE_0007, 1, 5'd5, 5'd7, 0, 0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'(i), 5'd7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while a response is in flight, then a tie after release must go to rq0.
    applyStimulus(0, 0, 0, 1, 5'd5, 5'd1, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("midreset_rq0_ready", {31'b0, rq0_ready}, 32'd0);
    checkOutput("midreset_rf_enable", {31'b0, rf_enable}, 32'd0);
    applyStimulus(1, 5'd9, 32'h9, 1, 5'd1, 5'd2, 1, 5'd3, 5'd4);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 5'd1, 5'd2, 1, 5'd3, 5'd5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic; requesters hold their fields until granted.
    r_wv = 0; r_v0 = 0; r_v1 = 0;
    r_wrd = 0; r_wdat = 0; r_a0 = 0; r_b0 = 0; r_a1 = 0; r_b1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!r_wv || wr_taken) begin
        r_wv = ($urandom_range(0, 99) < 45); r_wrd = 5'($urandom); r_wdat = $urandom;
      end
      if (!r_v0 || rq0_taken) begin
        r_v0 = ($urandom_range(0, 99) < 40); r_a0 = 5'($urandom); r_b0 = 5'($urandom);
      end
      if (!r_v1 || rq1_taken) begin
        r_v1 = ($urandom_range(0, 99) < 40); r_a1 = 5'($urandom); r_b1 = 5'($urandom);
      end
      applyStimulus(r_wv, r_wrd, r_wdat, r_v0, r_a0, r_b0, r_v1, r_a1, r_b1);
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_pending_rsp", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
